// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter / fetch-register stage:
// PC function encodings, NZCV bit positions and the fetch FSM states.
package pc_unit_pkg;

    // PC_FS encodings driven by the branch control unit
    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_PLUS4 = 2'b01;
    localparam logic [1:0] PC_IN    = 2'b10;
    localparam logic [1:0] PC_JUMP  = 2'b11;

    // Bit positions inside the 4-bit NZCV status register
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Fetch FSM: RUN fetches normally, WAIT freezes the PC until memory is ready
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_unit_branch_target_gen.sv
// branch_target_gen: PC-relative branch target, pc + (sign_extend(imm) << 2).
// imm26 = ir[25:0] (B/BL) or imm19 = ir[23:5] (CBZ/B.cond), chosen by i_imm_sel.
// Purely combinational; result wraps modulo 2^ADDR_W. Requires ADDR_W >= 28.
module branch_target_gen #(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [31:0]       i_ir,
    input  logic              i_imm_sel,
    output logic [ADDR_W-1:0] o_target
);

    logic [ADDR_W-1:0] w_imm26_ext;
    logic [ADDR_W-1:0] w_imm19_ext;
    logic [ADDR_W-1:0] w_offset;

    assign w_imm26_ext = {{(ADDR_W-26){i_ir[25]}}, i_ir[25:0]};
    assign w_imm19_ext = {{(ADDR_W-19){i_ir[23]}}, i_ir[23:5]};

    // Select the offset field, scale to a byte offset and add to the PC
    always_comb begin
        w_offset = i_imm_sel ? w_imm19_ext : w_imm26_ext;
        o_target = i_pc + (w_offset << 2);
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, instruction register, NZCV status register and a
// two-state fetch FSM that freezes the PC while instruction memory is not ready.
// Optional feature macro: PC_UNIT_MISALIGN_CHECK_EN -- when defined, a PC_IN
// load with pc_in[1:0] != 0 is word-aligned and raises the sticky o_misalign.
// Handshake: i_ir_load is a fetch request and i_mem_ready says i_instr is valid;
// a request without ready in RUN moves to WAIT, and the IR captures on the first
// cycle ready is seen (in RUN with the request, or in WAIT unconditionally).
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_pc_fs,
    input  logic [ADDR_W-1:0] i_pc_in,
    input  logic              i_imm_sel,
    input  logic              i_ir_load,
    input  logic [31:0]       i_instr,
    input  logic              i_mem_ready,
    input  logic              i_status_load,
    input  logic [3:0]        i_status_in,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_link,
    output logic [31:0]       o_ir,
    output logic              o_ir_valid,
    output logic [3:0]        o_status,
    output logic              o_fetch_stall,
    output logic              o_misalign,
    output logic              o_dbg_state
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_ir_valid;
    logic [3:0]        r_status;
    logic              w_pc_upd;
    logic              w_ir_cap;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_link;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_in_eff;

    branch_target_gen #(.ADDR_W(ADDR_W)) u_btg (
        .i_pc      (r_pc),
        .i_ir      (r_ir),
        .i_imm_sel (i_imm_sel),
        .o_target  (w_target)
    );

    assign w_pc_link = r_pc + PC_STEP;

`ifdef PC_UNIT_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign_req;

    assign w_pc_in_eff    = {i_pc_in[ADDR_W-1:2], 2'b00};
    assign w_misalign_req = (i_pc_fs == PC_IN) && (i_pc_in[1:0] != 2'b00);

    // Sticky misalignment flag, set only when the PC actually takes the load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_misalign <= 1'b0;
        else if (w_pc_upd && w_misalign_req)
            r_misalign <= 1'b1;
    end

    assign o_misalign = r_misalign;
`else
    assign w_pc_in_eff = i_pc_in;
    assign o_misalign  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_RUN;
        else
            r_state <= w_next_state;
    end

    // Next state, PC-update enable and IR-capture strobe
    always_comb begin
        w_next_state = r_state;
        w_pc_upd     = 1'b0;
        w_ir_cap     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_ir_load && !i_mem_ready) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_pc_upd = 1'b1;
                    w_ir_cap = i_ir_load;
                end
            end
            ST_WAIT: begin
                if (i_mem_ready) begin
                    w_next_state = ST_RUN;
                    w_ir_cap     = 1'b1;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Next PC selected by the PC function
    always_comb begin
        w_pc_next = r_pc;
        case (i_pc_fs)
            PC_PLUS4: w_pc_next = w_pc_link;
            PC_IN:    w_pc_next = w_pc_in_eff;
            PC_JUMP:  w_pc_next = w_target;
            default:  w_pc_next = r_pc;
        endcase
    end

    // PC register, frozen whenever the FSM withholds the update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pc <= RESET_PC;
        else if (w_pc_upd)
            r_pc <= w_pc_next;
    end

    // Instruction register and its sticky valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_ir_cap) begin
            r_ir       <= i_instr;
            r_ir_valid <= 1'b1;
        end
    end

    // NZCV status register, independent of the fetch FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_status <= 4'b0000;
        else if (i_status_load)
            r_status <= i_status_in;
    end

    assign o_pc          = r_pc;
    assign o_pc_link     = w_pc_link;
    assign o_ir          = r_ir;
    assign o_ir_valid    = r_ir_valid;
    assign o_status      = r_status;
    assign o_fetch_stall = (r_state == ST_WAIT);
    assign o_dbg_state   = r_state;

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and fetch-register stage that consumes the branch control unit's `PC_FS`, `IR_load` and `status_load` fields and produces the instruction word and status flags that the control unit decodes. It sits directly between instruction memory and the control unit. It holds the PC, computes PC-relative branch targets, latches the fetched instruction into the IR, and keeps the NZCV status register used by conditional and zero-test branches. A two-state fetch FSM freezes the PC while instruction memory is not ready.

## Interface

- `ADDR_W`, default 64: PC and address width.
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `PC_FS`  in  2: PC function.
  - 00: hold.
  - 01: PC+4.
  - 10: load `pc_in`.
  - 11: PC + branch offset.
- `pc_in`  in  ADDR_W: register-sourced target, used for BR/RET.
- `imm_sel`  in  1: offset source.
  - 0: imm26 = `ir[25:0]` (B/BL).
  - 1: imm19 = `ir[23:5]` (CBZ/B.cond).
- `IR_load`  in  1: capture `instr` into the IR this cycle.
- `instr`  in  32: instruction memory read data.
- `mem_ready`  in  1: `instr` is valid this cycle.
- `status_load`  in  1: load the status register.
- `status_in`  in  4: NZCV from the ALU.
- `pc`  out  ADDR_W: current PC; also the instruction memory address.
- `pc_link`  out  ADDR_W: combinational PC+4, used for BL writeback.
- `ir`  out  32: instruction register.
- `ir_valid`  out  1: the IR holds a captured instruction.
- `status`  out  4: NZCV register.
- `fetch_stall`  out  1: fetch FSM is in WAIT.
- `misalign`  out  1: a misaligned `pc_in` load was attempted. Present only with the check enabled (see Configuration).

## Operation

- **FSM states: RUN, WAIT.**
  - RUN → WAIT when `IR_load & ~mem_ready`.
  - WAIT → RUN on the cycle `mem_ready`=1. The IR captures `instr` on that edge.
- **PC update.** Occurs only in RUN, and only when not transitioning to WAIT.
  - The PC is frozen in WAIT and on the RUN→WAIT edge, whatever `PC_FS` is.
  - After the WAIT→RUN edge, `PC_FS` is honoured again from the next cycle onward.
- **Branch target.** `pc + (sign_extend(imm) << 2)`.
  - Width is ADDR_W; wrap-around is modulo 2^ADDR_W.
  - `imm` is taken from the current `ir`, not from `instr`.
- **PC+4.** Wraps modulo 2^ADDR_W; `RESET_PC` at 2^ADDR_W−4 rolls to 0.
- **IR capture.** The IR captures when `IR_load & mem_ready` in RUN, or when `mem_ready` in WAIT. `ir_valid` is set on capture and never cleared except by reset.
- **Status register.**
  - Loads `status_in` when `status_load`=1.
  - Independent of the FSM; loads even in WAIT.
- **Simultaneous events.**
  - `PC_FS`=10 or 11 together with `IR_load` in the same RUN cycle: the IR captures the old-PC instruction and the PC takes the new target.
  - `status_load` and a branch in the same cycle: the branch uses the old `ir` offset, and status updates in parallel.

## Timing

- Reset values:
  - `pc`=RESET_PC.
  - `ir`=0.
  - `ir_valid`=0.
  - `status`=0.
  - FSM=RUN.
  - `fetch_stall`=0.
  - `misalign`=0.
- Latency:
  - PC changes one edge after `PC_FS`.
  - IR is visible one edge after capture.
  - `status` is visible one edge after `status_load`.
- `pc_link` and `fetch_stall` are combinational from registered state; there is no input-to-output combinational path on `fetch_stall`.
- Reset asserted mid-WAIT: return to RUN with reset values immediately, with no dependence on the clock.

## Configuration

- `PC_UNIT_MISALIGN_CHECK_EN`:
  - **Defined:** a `PC_FS`=10 load with `pc_in[1:0]`≠0 writes `{pc_in[ADDR_W-1:2],2'b00}` to the PC and sets the sticky `misalign` flag. The flag is cleared only by reset.
  - **Undefined:** `pc_in` is loaded verbatim, and `misalign` is tied 0.

## Structure

- Shared package holds:
  - `PC_FS` encodings `PC_HOLD`/`PC_PLUS4`/`PC_IN`/`PC_JUMP`.
  - NZCV bit indices N=3, Z=2, C=1, V=0.
  - FSM enum RUN/WAIT.
- One sub-module, `branch_target_gen`: sign-extends imm26/imm19 per `imm_sel`, shifts left by 2 and adds to `pc`. Purely combinational.

## Test plan

- **Reset and step.** Reset with RESET_PC=0x100, then `PC_FS`=01 for 3 cycles → `pc`=0x10C, `pc_link`=0x110.
- **Backward branch.** `ir`=0x17FFFFFE (B, imm26=−2), `imm_sel`=0, `PC_FS`=11 at `pc`=0x200 → `pc`=0x1F8.
- **CBZ offset.** `ir` imm19=+5, `imm_sel`=1, `PC_FS`=11 at `pc`=0x40 → `pc`=0x54.
- **Fetch stall.**
  - `IR_load`=1 with `mem_ready`=0 for 2 cycles while `PC_FS`=01 → `fetch_stall`=1 and `pc` unchanged.
  - `mem_ready`=1 with `instr`=0xD503201F → `ir`=0xD503201F, `ir_valid`=1, `fetch_stall`=0.
- **Status independence.** `status_load`=1, `status_in`=0b0100 during WAIT → `status`=0b0100 next cycle.
- **Misalign check (macro defined).** `PC_FS`=10, `pc_in`=0x1003 → `pc`=0x1000, `misalign`=1. With the macro undefined → `pc`=0x1003, `misalign`=0.
